// File: rtl/usb_slavefifo_ctrl.sv
// usb_slavefifo_ctrl: CY68013 slave-FIFO master, EP2 -> rx stream, tx stream -> EP6.
// Define USB_PKTEND_EN to add tx_last / usb_pktend short-packet commit.
module usb_slavefifo_ctrl #(
    parameter int DW        = 16,
    parameter int BURST_LEN = 256,
    parameter int TURN_CYC  = 2
) (
    input  logic          cyp_clk,
    input  logic          rst,
    output logic [1:0]    usb_fifoaddr,
    output logic          usb_slcs,
    output logic          usb_sloe,
    output logic          usb_slrd,
    output logic          usb_slwr,
    input  logic [DW-1:0] usb_fd_i,
    output logic [DW-1:0] usb_fd_o,
    output logic          usb_fd_oe,
    input  logic          usb_flaga,
    input  logic          usb_flagc,
    output logic          pa0,
`ifdef USB_PKTEND_EN
    input  logic          tx_last,
    output logic          usb_pktend,
`endif
    input  logic [DW-1:0] tx_data,
    input  logic          tx_valid,
    output logic          tx_ready,
    output logic [DW-1:0] rx_data,
    output logic          rx_valid,
    input  logic          rx_ready
);

    localparam int CW = $clog2(BURST_LEN + 1);
    localparam int TW = $clog2(TURN_CYC + 1);
    localparam logic [CW-1:0] BL = CW'(BURST_LEN);
    localparam logic [TW-1:0] TL = TW'(TURN_CYC - 1);

    typedef enum logic [2:0] {IDLE, RD_SEL, RD, WR_SEL, WR, TURN} state_t;

    state_t        state_q, state_n;
    logic [CW-1:0] cnt_q, cnt_n;
    logic [TW-1:0] turn_q, turn_n;
    logic          rr_rd_q, rr_rd_n;
    logic          wr_pend_q, wr_pend_n;
    logic          slrd_n, slwr_n, tx_ready_n;
    logic [DW-1:0] fd_o_n;
    logic          rd_req, wr_req, room;
`ifdef USB_PKTEND_EN
    logic          last_q, last_n, pktend_n;
`endif

    assign pa0    = 1'b1;
    assign rd_req = usb_flaga && rx_ready;
    assign wr_req = usb_flagc && tx_valid;
    assign room   = cnt_q < BL;

    // Strobes are issued only while none is in flight, so the FX2 flags
    // have settled from the previous word before the next one is committed.
    always_comb begin
        state_n    = state_q;
        cnt_n      = cnt_q;
        turn_n     = '0;
        rr_rd_n    = rr_rd_q;
        wr_pend_n  = wr_pend_q;
        slrd_n     = 1'b1;
        slwr_n     = 1'b1;
        tx_ready_n = 1'b0;
        fd_o_n     = usb_fd_o;
`ifdef USB_PKTEND_EN
        last_n     = last_q;
        pktend_n   = 1'b1;
`endif
        unique case (state_q)
            IDLE: begin
                if (rd_req && !(wr_req && rr_rd_q)) begin
                    state_n = RD_SEL;
                end else if (wr_req) begin
                    state_n   = rr_rd_q ? TURN : WR_SEL;
                    wr_pend_n = rr_rd_q;
                end
            end
            RD_SEL: state_n = RD;
            RD: begin
                if (usb_slrd) begin
                    if (rd_req && room) begin
                        slrd_n = 1'b0;
                        cnt_n  = cnt_q + CW'(1);
                    end else begin
                        state_n = TURN;
                        rr_rd_n = 1'b1;
                    end
                end
            end
            WR_SEL: state_n = WR;
            WR: begin
`ifdef USB_PKTEND_EN
                if (!usb_pktend) begin
                    state_n = TURN;
                    rr_rd_n = 1'b0;
                end else if (!usb_slwr && last_q) begin
                    pktend_n = 1'b0;
                    last_n   = 1'b0;
                end else
`endif
                if (usb_slwr) begin
                    if (wr_req && room) begin
                        slwr_n     = 1'b0;
                        tx_ready_n = 1'b1;
                        fd_o_n     = tx_data;
                        cnt_n      = cnt_q + CW'(1);
`ifdef USB_PKTEND_EN
                        last_n     = tx_last;
`endif
                    end else begin
                        state_n = TURN;
                        rr_rd_n = 1'b0;
                    end
                end
            end
            TURN: begin
                cnt_n  = '0;
                turn_n = turn_q + TW'(1);
                if (turn_q == TL) begin
                    turn_n    = '0;
                    wr_pend_n = 1'b0;
                    state_n   = wr_pend_q ? WR_SEL : IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge cyp_clk) begin
        if (rst) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            turn_q       <= '0;
            rr_rd_q      <= 1'b0;
            wr_pend_q    <= 1'b0;
            usb_fifoaddr <= 2'b00;
            usb_slcs     <= 1'b1;
            usb_sloe     <= 1'b1;
            usb_slrd     <= 1'b1;
            usb_slwr     <= 1'b1;
            usb_fd_o     <= '0;
            usb_fd_oe    <= 1'b0;
            tx_ready     <= 1'b0;
            rx_valid     <= 1'b0;
            rx_data      <= '0;
`ifdef USB_PKTEND_EN
            last_q       <= 1'b0;
            usb_pktend   <= 1'b1;
`endif
        end else begin
            state_q      <= state_n;
            cnt_q        <= cnt_n;
            turn_q       <= turn_n;
            rr_rd_q      <= rr_rd_n;
            wr_pend_q    <= wr_pend_n;
            usb_fifoaddr <= (state_n inside {WR_SEL, WR}) ? 2'b10 : 2'b00;
            usb_slcs     <= !(state_n inside {RD_SEL, RD, WR_SEL, WR});
            usb_sloe     <= !(state_n inside {RD_SEL, RD});
            usb_fd_oe    <= state_n inside {WR_SEL, WR};
            usb_slrd     <= slrd_n;
            usb_slwr     <= slwr_n;
            usb_fd_o     <= fd_o_n;
            tx_ready     <= tx_ready_n;
            rx_valid     <= !usb_slrd;
            if (!usb_slrd) begin
                rx_data <= usb_fd_i;
            end
`ifdef USB_PKTEND_EN
            last_q       <= last_n;
            usb_pktend   <= pktend_n;
`endif
        end
    end

endmodule
